// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state codes and the
// 2-bit active-hazard cause encoding that the debug trace also decodes.
package hazard_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_ERROR    = 2'd2;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_MEM     = 2'd1,
    CAUSE_BRANCH  = 2'd2,
    CAUSE_LOADUSE = 2'd3
  } cause_t;

  // Branch beats load-use; the caller has already ruled out a busy memory.
  function automatic cause_t pick_cause(input logic branch, input logic load_use);
    if (branch) begin
      return CAUSE_BRANCH;
    end else if (load_use) begin
      return CAUSE_LOADUSE;
    end
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/hazard_mem_watchdog.sv
// Data-memory watchdog: counts frozen cycles of one outstanding access and
// pulses expire_o on the cycle whose edge would reach TIMEOUT.
module hazard_mem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = WD_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = inc_i & (cnt_q == LAST);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stall, taken-branch flush,
// memory-wait freeze with watchdog. Optional stall counter: HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_IF_ID,
  input  logic [REG_W-1:0] rs2_IF_ID,
  input  logic [REG_W-1:0] rd_ID_EX,
  input  logic             mem_read_ID_EX,
  input  logic             branch_taken_EX_MEM,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state_q, state_d;
  cause_t cause;
  logic   load_use, mem_busy;
  logic   wd_load, wd_inc, wd_clr, wd_expire;

  assign load_use = mem_read_ID_EX & (rd_ID_EX != '0) &
                    ((rd_ID_EX == rs1_IF_ID) | (rd_ID_EX == rs2_IF_ID));
  assign mem_busy = dmem_req & ~dmem_ready;

  // Kept outside the FSM block so the expiry compare does not loop through it.
  assign wd_load = (state_q == ST_RUN) & mem_busy;
  assign wd_inc  = (state_q == ST_MEM_WAIT) & ~dmem_ready;
  assign wd_clr  = (state_d == ST_RUN);

  hazard_mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .load_i   (wd_load),
    .inc_i    (wd_inc),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    cause   = CAUSE_NONE;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          cause   = CAUSE_MEM;
          state_d = ST_MEM_WAIT;
        end else begin
          cause = pick_cause(branch_taken_EX_MEM, load_use);
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          cause   = CAUSE_MEM;
          state_d = wd_expire ? ST_ERROR : ST_MEM_WAIT;
        end else begin
          cause   = pick_cause(branch_taken_EX_MEM, load_use);
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        cause = CAUSE_MEM;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    mem_timeout = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      mem_timeout = (state_q == ST_ERROR);
      case (cause)
        CAUSE_MEM: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_freeze = 1'b1;
        end
        CAUSE_BRANCH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        CAUSE_LOADUSE: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (TIMEOUT=4); stall counter
// expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout}
  localparam logic [5:0] E_NONE = 6'b110000;
  localparam logic [5:0] E_LU   = 6'b000100;
  localparam logic [5:0] E_BR   = 6'b111100;
  localparam logic [5:0] E_FRZ  = 6'b000010;
  localparam logic [5:0] E_ERR  = 6'b000011;
  localparam logic [5:0] E_RST  = 6'b001100;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1_IF_ID, rs2_IF_ID, rd_ID_EX;
  logic             mem_read_ID_EX, branch_taken_EX_MEM, dmem_req, dmem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic             pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  int               errors = 0;
  int               checks = 0;
  int               tag    = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  vec_t             tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_W   (5),
    .TIMEOUT (4),
    .CNT_W   (CNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rs1_IF_ID           (rs1_IF_ID),
    .rs2_IF_ID           (rs2_IF_ID),
    .rd_ID_EX            (rd_ID_EX),
    .mem_read_ID_EX      (mem_read_ID_EX),
    .branch_taken_EX_MEM (branch_taken_EX_MEM),
    .dmem_req            (dmem_req),
    .dmem_ready          (dmem_ready),
    .pc_write            (pc_write),
    .if_id_write         (if_id_write),
    .if_id_flush         (if_id_flush),
    .id_ex_flush         (id_ex_flush),
    .pipe_freeze         (pipe_freeze),
    .mem_timeout         (mem_timeout),
    .stall_cnt           (stall_cnt)
  );

  function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic l, input logic b,
                              input logic q, input logic y, input logic [5:0] e);
    vec_t v;
    v.rst = r; v.rs1 = s1; v.rs2 = s2; v.rd = d;
    v.ld = l; v.br = b; v.req = q; v.rdy = y; v.exp = e;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic [5:0] got;
    @(negedge clk);
    rst                 = v.rst;
    rs1_IF_ID           = v.rs1;
    rs2_IF_ID           = v.rs2;
    rd_ID_EX            = v.rd;
    mem_read_ID_EX      = v.ld;
    branch_taken_EX_MEM = v.br;
    dmem_req            = v.req;
    dmem_ready          = v.rdy;
    #1;
    got = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL step%0d_outputs: got %b required %b", tag, got, v.exp);
    end
    if (!v.rst) begin
      checks++;
      if (stall_cnt !== exp_stall) begin
        errors++;
        $display("FAIL step%0d_stall_cnt: got %0d required %0d", tag, stall_cnt, exp_stall);
      end
    end
    if (v.rst) begin
      exp_stall = '0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (!v.exp[5] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
`endif
    end
    tag++;
  endtask

  initial begin
    rst = 1'b1;
    rs1_IF_ID = '0; rs2_IF_ID = '0; rd_ID_EX = '0;
    mem_read_ID_EX = 1'b0; branch_taken_EX_MEM = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;

    //            rst rs1 rs2 rd  ld br rq rdy exp
    tbl.push_back(mk(1, 0,  0,  0,  0, 0, 0, 0, E_RST));
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 0, 0, E_NONE));
    tbl.push_back(mk(0, 1,  5,  5,  1, 0, 0, 0, E_LU));   // rs2 match
    tbl.push_back(mk(0, 1,  5,  5,  0, 0, 0, 0, E_NONE)); // bubble now in EX
    tbl.push_back(mk(0, 0,  0,  0,  1, 0, 0, 0, E_NONE)); // rd = x0
    tbl.push_back(mk(0, 7,  2,  7,  1, 0, 0, 0, E_LU));   // rs1 match
    tbl.push_back(mk(0, 7,  2,  7,  0, 0, 0, 0, E_NONE)); // not a load
    tbl.push_back(mk(0, 1,  5,  5,  1, 1, 0, 0, E_BR));   // branch beats load-use
    tbl.push_back(mk(0, 1,  2,  3,  0, 1, 0, 0, E_BR));
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 0, 1, E_NONE)); // ready without req
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 1, 0, E_FRZ));  // 3-cycle wait
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 1, 0, E_FRZ));
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 1, 0, E_FRZ));
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 1, 1, E_NONE));
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 0, 0, E_NONE));
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 1, 0, E_FRZ));
    tbl.push_back(mk(0, 1,  2,  3,  0, 1, 1, 1, E_BR));   // branch on ready cycle
    tbl.push_back(mk(0, 9,  2,  9,  1, 0, 1, 0, E_FRZ));  // busy beats load-use
    tbl.push_back(mk(0, 9,  2,  9,  1, 0, 1, 1, E_LU));   // load-use on ready cycle
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 0, 0, E_NONE));
    tbl.push_back(mk(0, 1,  2,  3,  0, 1, 1, 0, E_FRZ));  // busy beats branch
    tbl.push_back(mk(0, 1,  2,  3,  0, 1, 1, 1, E_BR));
    tbl.push_back(mk(0, 1,  2,  3,  0, 0, 0, 0, E_NONE));

    foreach (tbl[i]) step(tbl[i]);

    // Watchdog: four frozen cycles, then sticky error until reset.
    for (int i = 0; i < 4; i++) step(mk(0, 1, 2, 3, 0, 0, 1, 0, E_FRZ));
    step(mk(0, 1, 2, 3, 0, 0, 1, 0, E_ERR));
    step(mk(0, 1, 2, 3, 0, 0, 1, 1, E_ERR));
    step(mk(0, 1, 2, 3, 0, 0, 0, 0, E_ERR));
    step(mk(1, 1, 2, 3, 0, 0, 0, 0, E_RST));
    step(mk(0, 1, 2, 3, 0, 0, 0, 0, E_NONE));
    step(mk(0, 4, 2, 4, 1, 0, 0, 0, E_LU));
    step(mk(0, 1, 2, 3, 0, 0, 0, 0, E_NONE));

    // Reset in the middle of a memory wait.
    step(mk(0, 1, 2, 3, 0, 0, 1, 0, E_FRZ));
    step(mk(0, 1, 2, 3, 0, 0, 1, 0, E_FRZ));
    step(mk(1, 1, 2, 3, 0, 0, 1, 0, E_RST));
    step(mk(0, 1, 2, 3, 0, 0, 0, 0, E_NONE));
    for (int i = 0; i < 3; i++) step(mk(0, 1, 2, 3, 0, 0, 1, 0, E_FRZ));
    step(mk(0, 1, 2, 3, 0, 0, 1, 1, E_NONE));

    // Ten load-use stalls in a row.
    for (int i = 0; i < 10; i++) step(mk(0, 6, 1, 6, 1, 0, 0, 0, E_LU));
    step(mk(0, 1, 2, 3, 0, 0, 0, 0, E_NONE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
